// File: rtl/fpa_param_addsub.sv
// rtl/fpa_param_addsub.sv - multi-cycle parameterised float add/sub, truncating, no subnormals
module fpa_param_addsub #(
    parameter int EW = 4,
    parameter int MW = 3,
    localparam int W = EW + MW + 1
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         start,
    output logic         in_ready,
    input  logic         op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] ans,
    output logic [3:0]   ans_except,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [2:0]   state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ALIGN = 3'd2,
        S_ADD   = 3'd3,
        S_NORM  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [EW-1:0] EXP_MAX   = '1;
    localparam logic [EW-1:0] EXP_ONE   = EW'(1);
    localparam logic [EW-1:0] ALIGN_MAX = EW'(MW + 1);

    state_t          st;
    logic [W-1:0]    a_r, b_r;
    logic            sign_r, sub_r, inexact_r;
    logic [EW-1:0]   exp_r, d_r;
    logic [MW:0]     sig_gt, sig_ls;
    logic [MW+1:0]   sum_r;

    // Operand ordering and special-case decode, used only in LOAD
    logic            a_inf, b_inf, a_is_gt, gt_zero, ls_zero, inf_sign;
    logic [W-1:0]    gt_w, ls_w;
    logic [EW-1:0]   gt_exp, ls_exp, exp_inc;

    always_comb begin
        a_inf    = (a_r[W-2:MW] == EXP_MAX);
        b_inf    = (b_r[W-2:MW] == EXP_MAX);
        inf_sign = a_inf ? a_r[W-1] : b_r[W-1];
        a_is_gt  = (a_r[W-2:0] >= b_r[W-2:0]);
        gt_w     = a_is_gt ? a_r : b_r;
        ls_w     = a_is_gt ? b_r : a_r;
        gt_exp   = gt_w[W-2:MW];
        ls_exp   = ls_w[W-2:MW];
        gt_zero  = (gt_exp == '0);
        ls_zero  = (ls_exp == '0);
        exp_inc  = exp_r + 1'b1;
    end

    assign state = st;

    always_ff @(posedge clk) begin
        if (clr) begin
            st         <= S_IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            ans        <= '0;
            ans_except <= '0;
            a_r        <= '0;
            b_r        <= '0;
            sign_r     <= 1'b0;
            sub_r      <= 1'b0;
            inexact_r  <= 1'b0;
            exp_r      <= '0;
            d_r        <= '0;
            sig_gt     <= '0;
            sig_ls     <= '0;
            sum_r      <= '0;
        end else begin
            case (st)
                S_IDLE: begin
                    if (start) begin
                        a_r        <= a;
                        b_r        <= {b[W-1] ^ op, b[W-2:0]};
                        ans_except <= '0;
                        in_ready   <= 1'b0;
                        st         <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    if (a_inf || b_inf) begin
                        ans        <= {inf_sign, EXP_MAX, {MW{1'b0}}};
                        ans_except <= 4'b1000;
                        out_valid  <= 1'b1;
                        st         <= S_DONE;
                    end else begin
                        sign_r    <= gt_w[W-1];
                        sub_r     <= a_r[W-1] ^ b_r[W-1];
                        exp_r     <= gt_exp;
                        d_r       <= gt_exp - ls_exp;
                        sig_gt    <= gt_zero ? '0 : {1'b1, gt_w[MW-1:0]};
                        sig_ls    <= ls_zero ? '0 : {1'b1, ls_w[MW-1:0]};
                        inexact_r <= 1'b0;
                        st        <= ((gt_exp != ls_exp) && !ls_zero) ? S_ALIGN : S_ADD;
                    end
                end

                S_ALIGN: begin
                    // A shift past the whole significand drains it in a single cycle
                    if (d_r > ALIGN_MAX) begin
                        sig_ls    <= '0;
                        inexact_r <= 1'b1;
                        st        <= S_ADD;
                    end else begin
                        sig_ls    <= sig_ls >> 1;
                        inexact_r <= inexact_r | sig_ls[0];
                        d_r       <= d_r - 1'b1;
                        if (d_r == EXP_ONE)
                            st <= S_ADD;
                    end
                end

                S_ADD: begin
                    // gt >= ls after ordering and alignment, so the difference never goes negative
                    if (sub_r)
                        sum_r <= {1'b0, sig_gt} - {1'b0, sig_ls};
                    else
                        sum_r <= {1'b0, sig_gt} + {1'b0, sig_ls};
                    st <= S_NORM;
                end

                S_NORM: begin
                    if (sum_r == '0) begin
                        ans        <= '0;
                        ans_except <= {3'b001, inexact_r};
                        out_valid  <= 1'b1;
                        st         <= S_DONE;
                    end else if (sum_r[MW+1]) begin
                        if (exp_inc == EXP_MAX) begin
                            ans        <= {sign_r, EXP_MAX, {MW{1'b0}}};
                            ans_except <= {3'b100, inexact_r | sum_r[0]};
                        end else begin
                            ans        <= {sign_r, exp_inc, sum_r[MW:1]};
                            ans_except <= {3'b000, inexact_r | sum_r[0]};
                        end
                        out_valid <= 1'b1;
                        st        <= S_DONE;
                    end else if (!sum_r[MW]) begin
                        // Decrementing into exponent 0 would need a subnormal: flush to zero
                        if (exp_r == EXP_ONE) begin
                            ans        <= {sign_r, {EW{1'b0}}, {MW{1'b0}}};
                            ans_except <= {3'b011, inexact_r};
                            out_valid  <= 1'b1;
                            st         <= S_DONE;
                        end else begin
                            sum_r <= sum_r << 1;
                            exp_r <= exp_r - 1'b1;
                        end
                    end else begin
                        ans        <= {sign_r, exp_r, sum_r[MW-1:0]};
                        ans_except <= {3'b000, inexact_r};
                        out_valid  <= 1'b1;
                        st         <= S_DONE;
                    end
                end

                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        st        <= S_IDLE;
                    end
                end

                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    st        <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpa_param_addsub.sv
// tb/tb_fpa_param_addsub.sv - directed vector bench for fpa_param_addsub (EW=4, MW=3)
module tb_fpa_param_addsub;

    logic       clk = 1'b0;
    logic       clr, start, op, out_ready;
    logic [7:0] a, b;
    logic       in_ready, out_valid;
    logic [7:0] ans;
    logic [3:0] ans_except;
    logic [2:0] state;

    int n_cmp  = 0;
    int n_fail = 0;

    fpa_param_addsub #(.EW(4), .MW(3)) dut (
        .clk        (clk),
        .clr        (clr),
        .start      (start),
        .in_ready   (in_ready),
        .op         (op),
        .a          (a),
        .b          (b),
        .ans        (ans),
        .ans_except (ans_except),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .state      (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       op;
        logic [7:0] ans;
        logic [3:0] fl;
        int         lat;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic launch(input logic [7:0] va, input logic [7:0] vb, input logic vop);
        int guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
        a = va; b = vb; op = vop; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) check("out_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic drain();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        clr = 1'b1; start = 1'b0; op = 1'b0; out_ready = 1'b0; a = '0; b = '0;

        vecs[0]  = '{8'h38, 8'h38, 1'b0, 8'h40, 4'b0000, 3};
        vecs[1]  = '{8'h38, 8'h30, 1'b0, 8'h3C, 4'b0000, 4};
        vecs[2]  = '{8'h3C, 8'h3A, 1'b1, 8'h28, 4'b0000, 5};
        vecs[3]  = '{8'h38, 8'h38, 1'b1, 8'h00, 4'b0010, 3};
        vecs[4]  = '{8'h38, 8'h10, 1'b0, 8'h38, 4'b0001, 4};
        vecs[5]  = '{8'h77, 8'h77, 1'b0, 8'h78, 4'b1000, 3};
        vecs[6]  = '{8'h09, 8'h08, 1'b1, 8'h00, 4'b0110, -1};
        vecs[7]  = '{8'h78, 8'h38, 1'b0, 8'h78, 4'b1000, 1};
        vecs[8]  = '{8'h38, 8'hF8, 1'b0, 8'hF8, 4'b1000, 1};
        vecs[9]  = '{8'h38, 8'h00, 1'b0, 8'h38, 4'b0000, 3};
        vecs[10] = '{8'h3F, 8'h31, 1'b0, 8'h41, 4'b0001, 4};
        vecs[11] = '{8'hB8, 8'h30, 1'b0, 8'hB0, 4'b0000, 5};
        vecs[12] = '{8'h30, 8'h38, 1'b1, 8'hB0, 4'b0000, 5};
        vecs[13] = '{8'h38, 8'h18, 1'b0, 8'h38, 4'b0001, 7};

        repeat (2) @(posedge clk);
        #1;
        clr = 1'b0;
        check("reset_state", 32'(state), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_ans", 32'(ans), 32'd0);
        check("reset_flags", 32'(ans_except), 32'd0);

        for (int i = 0; i < 14; i++) begin
            launch(vecs[i].a, vecs[i].b, vecs[i].op);
            wait_valid(lat);
            check($sformatf("vec%0d_ans", i), 32'(ans), 32'(vecs[i].ans));
            check($sformatf("vec%0d_flags", i), 32'(ans_except), 32'(vecs[i].fl));
            if (vecs[i].lat >= 0)
                check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            drain();
            check($sformatf("vec%0d_back_idle", i), 32'({state, in_ready, out_valid}), 32'({3'd0, 1'b1, 1'b0}));
        end

        // Flags clear at acceptance while ans keeps the previous result
        launch(8'h38, 8'h10, 1'b0);
        wait_valid(lat);
        drain();
        launch(8'h38, 8'h38, 1'b0);
        check("accept_flags_cleared", 32'(ans_except), 32'd0);
        check("accept_ans_held", 32'(ans), 32'h38);
        wait_valid(lat);
        check("accept_next_ans", 32'(ans), 32'h40);
        drain();

        // Consumer stall: result held, start ignored
        launch(8'h38, 8'h30, 1'b0);
        wait_valid(lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start = 1'b1; a = 8'h77; b = 8'h77; op = 1'b0;
            @(posedge clk);
            #1;
            check($sformatf("stall%0d_ans", i), 32'(ans), 32'h3C);
            check($sformatf("stall%0d_flags", i), 32'(ans_except), 32'd0);
            check($sformatf("stall%0d_state", i), 32'({state, out_valid, in_ready}), 32'({3'd5, 1'b1, 1'b0}));
        end
        start = 1'b0;
        drain();
        check("stall_back_idle", 32'(state), 32'd0);

        // Start during ALIGN is ignored
        launch(8'h38, 8'h18, 1'b0);
        @(posedge clk);
        #1;
        check("align_state", 32'(state), 32'd2);
        @(negedge clk);
        start = 1'b1; a = 8'h77; b = 8'h77;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_valid(lat);
        check("align_ignore_ans", 32'(ans), 32'h38);
        check("align_ignore_flags", 32'(ans_except), 32'b0001);
        check("align_ignore_latency", 32'(lat + 2), 32'd7);
        drain();

        // clr mid-ALIGN, with start asserted alongside, aborts the operation
        launch(8'h38, 8'h18, 1'b0);
        @(posedge clk);
        #1;
        check("clr_pre_state", 32'(state), 32'd2);
        @(negedge clk);
        clr = 1'b1; start = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0; start = 1'b0; out_ready = 1'b0;
        check("clr_state", 32'(state), 32'd0);
        check("clr_in_ready", 32'(in_ready), 32'd1);
        check("clr_out_valid", 32'(out_valid), 32'd0);
        check("clr_ans", 32'({ans, ans_except}), 32'd0);
        launch(8'h38, 8'h38, 1'b0);
        wait_valid(lat);
        check("post_clr_ans", 32'(ans), 32'h40);
        check("post_clr_latency", 32'(lat), 32'd3);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fpa_param_addsub.md
FPA_PARAM_ADDSUB -- requirements
Module: fpa_param_addsub

Interface
REQ-001 Parameter EW, default 4, exponent width in bits (>=3); bias = 2^(EW-1)-1.
REQ-002 Parameter MW, default 3, stored mantissa width in bits (>=2); hidden leading 1 implied.
REQ-003 Parameter W = EW+MW+1, derived; operand/result word = {sign, exp[EW-1:0], mant[MW-1:0]}.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 clr  input  1  reset; one clock; reset is synchronous and active-high.
REQ-006 start  input  1  request valid; accepted on the edge where start & in_ready.
REQ-007 in_ready  output  1  high only in IDLE.
REQ-008 op  input  1  0 = a+b, 1 = a-b; sampled with a, b at acceptance.
REQ-009 a, b  input  W  operands.
REQ-010 ans  output  W  result, registered, stable while out_valid.
REQ-011 ans_except  output  4  flags: [3] overflow, [2] underflow, [1] zero, [0] inexact.
REQ-012 out_valid  output  1  high in DONE.
REQ-013 out_ready  input  1  consumer accept; result transfers on edge with out_valid & out_ready.
REQ-014 state  output  3  current FSM state, debug.

Function
REQ-015 States/encodings: IDLE=0, LOAD=1, ALIGN=2, ADD=3, NORM=4, DONE=5; others decode to IDLE next cycle.
REQ-016 IDLE: on start -> LOAD, capture a, b, op; b sign inverted when op=1; start ignored in every other state.
REQ-017 Exp field 0 = value zero (no subnormals), mantissa ignored; exp all-ones = reserved overflow code.
REQ-018 LOAD (1 cycle): order operands so "gt" has larger {exp,mant}, ties keep a; d = exp_gt - exp_ls; -> ALIGN if d>0 and ls nonzero, else -> ADD.
REQ-019 LOAD: if either operand exp all-ones -> DONE; ans = {sign of that operand (a if both), all-ones, 0}; flags 1000.
REQ-020 ALIGN: if d > MW+1, ls significand forced 0 in one cycle, inexact set; else shift ls right 1 bit/cycle for d cycles, inexact ORed with each bit shifted out; -> ADD.
REQ-021 ADD (1 cycle): MW+2-bit sum/difference of {1,mant} significands (zero operand contributes 0); subtract when signs differ; result sign = sign of gt; -> NORM.
REQ-022 NORM, one evaluation per cycle: sum 0 -> ans +0, zero flag, -> DONE; carry set -> shift right 1, exp+1, lost bit ORed into inexact, -> DONE; hidden bit 0 -> shift left 1, exp-1, stay; hidden bit 1 -> DONE.
REQ-023 Exp reaching all-ones in NORM -> ans {sign,all-ones,0}, flags overflow (+inexact as accumulated).
REQ-024 Exp reaching 0 before normalised -> ans {sign,0,0}, flags underflow|zero (0110).
REQ-025 Rounding: truncation toward zero only.
REQ-026 Latency: out_valid first high 2 + d' + k edges after the accepting edge; d' = align cycles, k = NORM cycles (>=1).
REQ-027 DONE: hold ans, ans_except, out_valid until out_valid & out_ready, then -> IDLE; new start accepted no earlier than the following cycle.
REQ-028 Flags cleared at each acceptance; ans changes only on entry to DONE.

Reset
REQ-029 clr in any state, including mid-operation, forces IDLE on the next edge: in_ready=1, out_valid=0, ans=0, ans_except=0, state=0; in-flight operation discarded.
REQ-030 clr has priority over start and out_ready in the same cycle.

Verification (EW=4, MW=3)
REQ-031 a=0x38, b=0x38, op=0 -> ans 0x40, flags 0000, out_valid 3 edges after acceptance.
REQ-032 a=0x38, b=0x30, op=0 -> ans 0x3C, flags 0000, latency 4; a=0x3C, b=0x3A, op=1 -> ans 0x28, latency 5.
REQ-033 a=0x38, b=0x38, op=1 -> ans 0x00, flags 0010; a=0x38, b=0x10, op=0 -> ans 0x38, flags 0001.
REQ-034 a=0x77, b=0x77, op=0 -> ans 0x78, flags 1000; a=0x09, b=0x08, op=1 -> ans 0x00, flags 0110.
REQ-035 out_ready held low 5 cycles in DONE -> ans/flags stable, start ignored; start during ALIGN ignored.
REQ-036 clr asserted during ALIGN -> next edge state=0, in_ready=1, out_valid=0; new op then completes normally.
